// File: rtl/bnn_decrypt_loader.sv
// bnn_decrypt_loader: feeds cipher bytes to the byte decryptor, packs plain bytes into weight words.
// Optional DEC_TIMEOUT_EN adds a dec_done watchdog with sticky err.
module bnn_decrypt_loader #(
    parameter int WORD_BYTES     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cin_valid,
    input  logic [7:0]                    cin_data,
    output logic                          cin_ready,
    input  logic                          flush,
    output logic                          dec_start,
    output logic [7:0]                    dec_cipher,
    input  logic [7:0]                    dec_plain,
    input  logic                          dec_done,
    output logic                          w_valid,
    output logic [8*WORD_BYTES-1:0]       w_data,
    input  logic                          w_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          err
);
    localparam int WW = 8 * WORD_BYTES;
    localparam int BW = $clog2(WORD_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_DONE = 2'd1;
    localparam logic [1:0] S_WAIT_CLR  = 2'd2;
    localparam logic [1:0] S_FLUSH     = 2'd3;

    localparam logic [BW-1:0] LAST_IDX = BW'(WORD_BYTES - 1);

    logic [1:0]    state;
    logic [BW-1:0] byte_idx;
    logic [WW-1:0] asm_q;
    logic [WW-1:0] asm_lane;
    logic          flush_pending;
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          accept;
    logic          done_take;
    logic          push;
    logic          pop;
    logic [WW-1:0] push_data;
    logic          timeout;

    assign cin_ready = !rst && (state == S_IDLE) && !flush_pending
                       && (count < CW'(FIFO_DEPTH));
    assign accept    = cin_valid && cin_ready;
    assign done_take = (state == S_WAIT_DONE) && dec_done;
    assign push      = (done_take && (byte_idx == LAST_IDX)) || (state == S_FLUSH);
    assign push_data = (state == S_FLUSH) ? asm_q : asm_lane;
    assign pop       = w_valid && w_ready;
    assign w_valid   = (count != '0);
    assign w_data    = mem[rd_ptr];
    assign fifo_count = count;
    assign busy      = (state != S_IDLE) || (byte_idx != '0);

    // Assembly word with the incoming plain byte dropped into its lane
    always_comb begin
        asm_lane = asm_q;
        asm_lane[{byte_idx, 3'b000} +: 8] = dec_plain;
    end

`ifdef DEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;

    assign timeout = (state == S_WAIT_DONE) && !dec_done
                     && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign err = err_q;

    // Watchdog: count WAIT_DONE cycles without completion, latch err on expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state == S_WAIT_DONE) && !dec_done) tcnt <= tcnt + 1'b1;
            else tcnt <= '0;
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Sequencer FSM: one byte per decryptor round trip, flush serviced from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            byte_idx      <= '0;
            asm_q         <= '0;
            flush_pending <= 1'b0;
            dec_start     <= 1'b0;
            dec_cipher    <= '0;
        end else begin
            if (flush)
                flush_pending <= 1'b1;
            else if ((state == S_FLUSH) ||
                     ((state == S_IDLE) && flush_pending && (byte_idx == '0)))
                flush_pending <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        dec_cipher <= cin_data;
                        dec_start  <= 1'b1;
                        state      <= S_WAIT_DONE;
                    end else if (flush_pending && (byte_idx != '0)) begin
                        state <= S_FLUSH;
                    end
                end
                S_WAIT_DONE: begin
                    if (dec_done) begin
                        dec_start <= 1'b0;
                        state     <= S_WAIT_CLR;
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            asm_q    <= '0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            asm_q    <= asm_lane;
                        end
                    end else if (timeout) begin
                        dec_start <= 1'b0;
                        state     <= S_WAIT_CLR;
                    end
                end
                S_WAIT_CLR: begin
                    if (!dec_done) state <= S_IDLE;
                end
                S_FLUSH: begin
                    asm_q    <= '0;
                    byte_idx <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FIFO storage, contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_bnn_decrypt_loader.sv
// tb_bnn_decrypt_loader: directed checks of the loader against a 3-cycle
// XOR-3C decryptor model.
module tb_bnn_decrypt_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cin_valid = 1'b0;
    logic [7:0]  cin_data = '0;
    logic        cin_ready;
    logic        flush = 1'b0;
    logic        dec_start;
    logic [7:0]  dec_cipher;
    logic [7:0]  dec_plain = '0;
    logic        dec_done = 1'b0;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        err;

    int compared = 0;
    int mismatched = 0;
    logic hang = 1'b0;
    logic [1:0] mcnt = '0;
    logic prev_start = 1'b0;

    bnn_decrypt_loader dut (
        .clk(clk), .rst(rst), .cin_valid(cin_valid), .cin_data(cin_data),
        .cin_ready(cin_ready), .flush(flush), .dec_start(dec_start),
        .dec_cipher(dec_cipher), .dec_plain(dec_plain), .dec_done(dec_done),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .fifo_count(fifo_count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Decryptor model: done 3 cycles after start, drops 1 cycle after start falls
    always @(posedge clk) begin
        if (rst || !dec_start) begin
            mcnt     <= '0;
            dec_done <= 1'b0;
        end else if (!hang) begin
            if (mcnt == 2'd2) begin
                dec_done  <= 1'b1;
                dec_plain <= dec_cipher ^ 8'h3C;
            end else begin
                mcnt <= mcnt + 1'b1;
            end
        end
    end

    // A new dec_start must never see a stale dec_done
    always @(negedge clk) begin
        prev_start <= dec_start;
        if (dec_start && !prev_start) begin
            compared++;
            if (dec_done) begin
                mismatched++;
                $display("FAIL start_while_done: dec_done=%b required 0", dec_done);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cin_valid = 1'b0;
        flush = 1'b0;
        w_ready = 1'b0;
        hang = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        cin_valid = 1'b1;
        cin_data  = b;
        while (!cin_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cin_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: cin_ready=%b required 1", cin_ready);
        end
        @(negedge clk);
        cin_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic pop_check(input logic [31:0] exp, input string nm);
        compared++;
        if (w_valid !== 1'b1 || w_data !== exp) begin
            mismatched++;
            $display("FAIL %s: w_valid=%b w_data=%h required 1 %h", nm, w_valid, w_data, exp);
        end
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({dec_start, dec_cipher, cin_ready, w_valid, fifo_count, busy, err} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: start=%b cipher=%h rdy=%b wv=%b cnt=%0d busy=%b err=%b required all 0",
                     dec_start, dec_cipher, cin_ready, w_valid, fifo_count, busy, err);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (cin_ready !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: rdy=%b cnt=%0d busy=%b required 1 0 0", cin_ready, fifo_count, busy);
        end
    endtask

    task automatic test_word();
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (10) @(negedge clk);
        compared++;
        if (fifo_count !== 3'd1 || w_valid !== 1'b1 || w_data !== 32'h780F1E2D) begin
            mismatched++;
            $display("FAIL word_pack: cnt=%0d wv=%b data=%h required 1 1 780f1e2d", fifo_count, w_valid, w_data);
        end
        compared++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL word_idle: busy=%b err=%b required 0 0", busy, err);
        end
    endtask

    task automatic test_back_to_back();
        int stall_bad = 0;
        do_reset();
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        repeat (10) @(negedge clk);
        compared++;
        if (fifo_count !== 3'd4 || cin_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL fifo_full: cnt=%0d rdy=%b required 4 0", fifo_count, cin_ready);
        end
        cin_valid = 1'b1;
        cin_data  = 8'h55;
        repeat (5) begin
            @(negedge clk);
            if (cin_ready !== 1'b0 || dec_start !== 1'b0) stall_bad++;
        end
        compared++;
        if (stall_bad != 0) begin
            mismatched++;
            $display("FAIL full_stall: bad_cycles=%0d required 0", stall_bad);
        end
        pop_check(32'h383F3E3D, "pop0");
        @(negedge clk);
        cin_valid = 1'b0;
        repeat (10) @(negedge clk);
        compared++;
        if (fifo_count !== 3'd3 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL byte17_taken: cnt=%0d busy=%b required 3 1", fifo_count, busy);
        end
        pulse_flush();
        repeat (3) @(negedge clk);
        compared++;
        if (fifo_count !== 3'd4) begin
            mismatched++;
            $display("FAIL flush17: cnt=%0d required 4", fifo_count);
        end
        pop_check(32'h343B3A39, "pop1");
        pop_check(32'h30373635, "pop2");
        pop_check(32'h2C333231, "pop3");
        pop_check(32'h00000069, "pop4");
        compared++;
        if (w_valid !== 1'b0 || fifo_count !== 3'd0) begin
            mismatched++;
            $display("FAIL drained: wv=%b cnt=%0d required 0 0", w_valid, fifo_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        send_byte(8'hA0);
        send_byte(8'hB0);
        repeat (10) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || fifo_count !== 3'd0) begin
            mismatched++;
            $display("FAIL partial: busy=%b cnt=%0d required 1 0", busy, fifo_count);
        end
        pulse_flush();
        repeat (3) @(negedge clk);
        compared++;
        if (fifo_count !== 3'd1 || w_data !== 32'h00008C9C || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_word: cnt=%0d data=%h busy=%b required 1 00008c9c 0", fifo_count, w_data, busy);
        end
        pulse_flush();
        repeat (3) @(negedge clk);
        compared++;
        if (fifo_count !== 3'd1 || cin_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL empty_flush: cnt=%0d rdy=%b busy=%b required 1 1 0", fifo_count, cin_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
        repeat (10) @(negedge clk);
        send_byte(8'h77);
        compared++;
        if (dec_start !== 1'b1 || fifo_count !== 3'd2 || dec_cipher !== 8'h77) begin
            mismatched++;
            $display("FAIL pre_abort: start=%b cnt=%0d cipher=%h required 1 2 77", dec_start, fifo_count, dec_cipher);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (dec_start !== 1'b0 || fifo_count !== 3'd0 || w_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort: start=%b cnt=%0d wv=%b busy=%b required 0 0 0 0", dec_start, fifo_count, w_valid, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
`ifdef DEC_TIMEOUT_EN
        do_reset();
        hang = 1'b1;
        send_byte(8'h99);
        repeat (70) @(negedge clk);
        compared++;
        if (err !== 1'b1 || dec_start !== 1'b0) begin
            mismatched++;
            $display("FAIL watchdog: err=%b start=%b required 1 0", err, dec_start);
        end
        hang = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(8'h12);
        repeat (10) @(negedge clk);
        pulse_flush();
        repeat (3) @(negedge clk);
        compared++;
        if (err !== 1'b1 || fifo_count !== 3'd1 || w_data !== 32'h0000002E) begin
            mismatched++;
            $display("FAIL after_timeout: err=%b cnt=%0d data=%h required 1 1 0000002e", err, fifo_count, w_data);
        end
`else
        do_reset();
        send_byte(8'h99);
        repeat (80) @(negedge clk);
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL err_tied: err=%b required 0", err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bnn_decrypt_loader.md
Name: bnn_decrypt_loader

Overview:
- Upstream sequencer for the lightweight byte decryptor in the Secure BNN accelerator. It accepts encrypted weight bytes from a ready/valid stream and drives the decryptor's start/done handshake one byte at a time.
- It packs the decrypted bytes, LSB-first, into WORD_BYTES-wide weight words. Words are buffered in a small FIFO that feeds the BNN weight memory through a ready/valid port.

Parameters:
- WORD_BYTES, 4, decrypted bytes per output weight word (>=2)
- FIFO_DEPTH, 4, output word FIFO entries (power of 2, >=2)
- TIMEOUT_CYCLES, 64, watchdog limit on dec_done wait (used only with DEC_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cin_valid  in  1  encrypted byte available
- cin_data  in  8  encrypted byte
- cin_ready  out  1  loader accepts cin_data this cycle
- flush  in  1  pulse: emit a partially filled word, zero-padded
- dec_start  out  1  start request to the decryptor
- dec_cipher  out  8  byte being decrypted, held stable while dec_start=1
- dec_plain  in  8  decrypted byte, valid while dec_done=1
- dec_done  in  1  decryptor completion (level, stays high until dec_start drops)
- w_valid  out  1  FIFO not empty
- w_data  out  8*WORD_BYTES  FIFO head word
- w_ready  in  1  consumer takes head word
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words buffered
- busy  out  1  state != IDLE or byte_idx != 0
- err  out  1  sticky watchdog error (tied 0 without DEC_TIMEOUT_EN)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; byte_idx=0; assembly register=0; FIFO empty.
  - Outputs after reset: dec_start=0, dec_cipher=0, cin_ready=0, w_valid=0, fifo_count=0, busy=0, err=0.
  - rst mid-operation aborts everything. dec_start drops the next cycle, and any partial word and all FIFO contents are discarded.
- FSM states: IDLE, WAIT_DONE, WAIT_CLR, FLUSH.
- IDLE:
  - cin_ready = (fifo_count < FIFO_DEPTH) && !flush_pending. This is combinational from registered state.
  - On cin_valid && cin_ready: latch cin_data into dec_cipher, set dec_start=1 (registered, high the next cycle), go to WAIT_DONE.
  - Otherwise, if flush_pending && byte_idx != 0, go to FLUSH.
  - If flush_pending && byte_idx == 0, clear flush_pending with no push.
- flush pulse in any state sets flush_pending. It is serviced only from IDLE; the byte in flight completes first.
- WAIT_DONE:
  - dec_start=1 and dec_cipher is held.
  - On dec_done=1: write dec_plain into byte lane byte_idx of the assembly register, set dec_start=0, go to WAIT_CLR.
  - If byte_idx == WORD_BYTES-1, push {lanes} into the FIFO in the same cycle and set byte_idx=0; else byte_idx+1.
- WAIT_CLR: hold dec_start=0 until dec_done=0, then go to IDLE. This prevents a stale dec_done being taken as completion of the next byte.
- FLUSH: push the assembly register with unfilled upper lanes = 0. Then byte_idx=0, clear assembly and flush_pending, go to IDLE. Takes one cycle.
- FIFO:
  - w_data is the head entry; pop on w_valid && w_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A push can never hit a full FIFO: a byte is accepted only with space free, and only pops occur before its push.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Throughput: at most one byte per decryptor round trip. Minimum loader overhead is 1 cycle in IDLE plus 1 cycle in WAIT_CLR beyond the decryptor latency.

Optional Feature:
- Macro: DEC_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE. If dec_done has not been seen after TIMEOUT_CYCLES cycles, set err=1 (sticky until rst), drop dec_start, and go to WAIT_CLR.
  - The lost byte is skipped; byte_idx does not advance.
- Undefined: no counter; WAIT_DONE waits indefinitely; err is constant 0.

Test Plan:
- Bench decryptor model: dec_done rises 3 cycles after dec_start, plain = cipher ^ 8'h3C, done falls 1 cycle after start drops.
- Reset then idle -> all outputs 0, cin_ready=1 after reset release, fifo_count=0.
- Stream 8'h11,22,33,44 with w_ready=0 -> one word w_data=32'h780F1E2D, fifo_count=1, w_valid=1. dec_start never re-asserts before dec_done returns low.
- 16 bytes with w_ready=0 -> fifo_count=4, cin_ready=0. The 17th byte stalls until one w_ready pop, then is accepted; no word lost or duplicated.
- Bytes 8'hA0,8'hB0 then flush -> w_data=32'h00008C9C, byte_idx back to 0. Flush with byte_idx=0 -> no push.
- rst asserted during WAIT_DONE with 2 words buffered -> next cycle dec_start=0, fifo_count=0, w_valid=0, busy=0.
- DEC_TIMEOUT_EN, model never asserts dec_done -> after 64 cycles err=1, dec_start=0. The next byte proceeds normally and err stays 1.
